// File: rtl/gs_pkg.sv
// Shared GoldenSnitch IF-control definitions.
// PC source encodings and the fetch sequencer state type.
package gs_pkg;

    localparam logic [3:0] PC_BOOT   = 4'd0;
    localparam logic [3:0] PC_NORMAL = 4'd1;
    localparam logic [3:0] PC_BRNACH = 4'd2;
    localparam logic [3:0] PC_JUMP   = 4'd3;

    typedef enum logic [2:0] {
        RST_WAIT = 3'd0,
        BOOT     = 3'd1,
        RUN      = 3'd2,
        PEND     = 3'd3,
        SLEEP    = 3'd4,
        WAKE     = 3'd5
    } if_ctrl_state_e;

endpackage

// File: rtl/gs_if_ctrl_if.sv
// Control bundle between the fetch sequencer and its neighbours.
// master drives the request side, slave is the sequencer.
interface gs_if_ctrl_if #(
    parameter int ADDR_SIZE = 32
);

    logic                 fetch_en_i;
    logic                 br_taken_i;
    logic [ADDR_SIZE-1:0] br_addr_i;
    logic                 jump_i;
    logic [ADDR_SIZE-1:0] jump_addr_i;
    logic [ADDR_SIZE-1:0] pc_i;
    logic                 ld_use_i;
    logic                 id_ready_i;
    logic                 mem_busy_i;
    logic [3:0]           pc_mux_sel_o;
    logic [ADDR_SIZE-1:0] br_addr_o;
    logic [ADDR_SIZE-1:0] jump_addr_o;
    logic                 halt_if_o;
    logic                 flush_if_o;
    logic                 flush_id_o;
    logic                 boot_done_o;
    logic [31:0]          redirect_cnt_o;
    logic [31:0]          stall_cnt_o;

    modport master (
        output fetch_en_i, br_taken_i, br_addr_i,
        output jump_i, jump_addr_i, pc_i,
        output ld_use_i, id_ready_i, mem_busy_i,
        input  pc_mux_sel_o, br_addr_o, jump_addr_o,
        input  halt_if_o, flush_if_o, flush_id_o,
        input  boot_done_o, redirect_cnt_o, stall_cnt_o
    );

    modport slave (
        input  fetch_en_i, br_taken_i, br_addr_i,
        input  jump_i, jump_addr_i, pc_i,
        input  ld_use_i, id_ready_i, mem_busy_i,
        output pc_mux_sel_o, br_addr_o, jump_addr_o,
        output halt_if_o, flush_if_o, flush_id_o,
        output boot_done_o, redirect_cnt_o, stall_cnt_o
    );

endinterface

// File: rtl/gs_sat_counter.sv
// Saturating event counter used for the IF perf statistics.
module gs_sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_i,
    output logic [WIDTH-1:0] cnt_o
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_o <= '0;
        end else if (inc_i && (cnt_o != '1)) begin
            cnt_o <= cnt_o + 1'b1;
        end
    end

endmodule

// File: rtl/gs_if_ctrl.sv
// GoldenSnitch IF fetch sequencer: boot, redirects, stalls, sleep/wake.
// GS_IF_CTRL_PERF_EN enables the redirect/stall perf counters.
module gs_if_ctrl
    import gs_pkg::*;
#(
    parameter int BOOT_DELAY = 2,
    parameter int ADDR_SIZE  = 32
) (
    input logic         clk,
    input logic         rst,
    gs_if_ctrl_if.slave bus
);

    localparam logic [2:0] WAIT_MAX = 3'(BOOT_DELAY - 1);

    if_ctrl_state_e       state;
    if_ctrl_state_e       state_nx;
    logic [2:0]           wait_cnt;
    logic [ADDR_SIZE-1:0] pend_addr;
    logic [ADDR_SIZE-1:0] pend_nx;
    logic [ADDR_SIZE-1:0] resume_pc;
    logic [ADDR_SIZE-1:0] resume_nx;
    logic                 boot_done;
    logic [3:0]           sel;
    logic                 halt;
    logic                 flush_if;
    logic                 flush_id;
    logic                 issue;
    logic                 stall;
    logic                 redir;
    logic [ADDR_SIZE-1:0] redir_addr;
    logic                 go_sleep;
    logic                 go_pend;
    logic                 go_redir;

    assign redir      = bus.br_taken_i | bus.jump_i;
    assign redir_addr = bus.br_taken_i ? bus.br_addr_i
                                       : bus.jump_addr_i;

    // Sleep wins over any redirect; its target becomes the resume PC.
    assign go_sleep = ~bus.fetch_en_i;
    assign go_pend  = bus.fetch_en_i & redir & bus.mem_busy_i;
    assign go_redir = bus.fetch_en_i & redir & ~bus.mem_busy_i;

    always_comb begin
        state_nx  = state;
        pend_nx   = pend_addr;
        resume_nx = resume_pc;
        sel       = PC_NORMAL;
        halt      = 1'b1;
        flush_if  = 1'b0;
        flush_id  = 1'b0;
        issue     = 1'b0;
        unique case (state)
            RST_WAIT: begin
                if (wait_cnt == WAIT_MAX && bus.fetch_en_i)
                    state_nx = BOOT;
            end
            BOOT: begin
                sel      = PC_BOOT;
                halt     = 1'b0;
                state_nx = RUN;
            end
            RUN: begin
                unique case (1'b1)
                    go_sleep: begin
                        flush_if  = 1'b1;
                        resume_nx = redir ? redir_addr : bus.pc_i;
                        state_nx  = SLEEP;
                    end
                    go_pend: begin
                        flush_id = 1'b1;
                        pend_nx  = redir_addr;
                        state_nx = PEND;
                    end
                    go_redir: begin
                        flush_id = 1'b1;
                        halt     = 1'b0;
                        issue    = 1'b1;
                        sel      = bus.br_taken_i ? PC_BRNACH
                                                  : PC_JUMP;
                    end
                    default: begin
                        halt = bus.ld_use_i | ~bus.id_ready_i
                             | bus.mem_busy_i;
                    end
                endcase
            end
            PEND: begin
                flush_id = 1'b1;
                if (!bus.fetch_en_i) begin
                    flush_if  = 1'b1;
                    resume_nx = pend_addr;
                    state_nx  = SLEEP;
                end else if (!bus.mem_busy_i) begin
                    sel      = PC_BRNACH;
                    halt     = 1'b0;
                    issue    = 1'b1;
                    state_nx = RUN;
                end
            end
            SLEEP: begin
                if (bus.br_taken_i)
                    resume_nx = bus.br_addr_i;
                else if (bus.jump_i)
                    resume_nx = bus.jump_addr_i;
                if (bus.fetch_en_i)
                    state_nx = WAKE;
            end
            WAKE: begin
                sel  = PC_JUMP;
                halt = bus.mem_busy_i;
                if (!bus.mem_busy_i)
                    state_nx = RUN;
            end
            default: state_nx = RST_WAIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= RST_WAIT;
            wait_cnt  <= '0;
            pend_addr <= '0;
            resume_pc <= '0;
            boot_done <= 1'b0;
        end else begin
            state     <= state_nx;
            pend_addr <= pend_nx;
            resume_pc <= resume_nx;
            if (state == RST_WAIT && wait_cnt != WAIT_MAX)
                wait_cnt <= wait_cnt + 3'd1;
            if (state == BOOT)
                boot_done <= 1'b1;
        end
    end

    assign stall = (state == RUN) & halt;

    assign bus.pc_mux_sel_o = sel;
    assign bus.halt_if_o    = halt;
    assign bus.flush_if_o   = flush_if;
    assign bus.flush_id_o   = flush_id;
    assign bus.boot_done_o  = boot_done;
    assign bus.br_addr_o    = (state == PEND) ? pend_addr
                                              : bus.br_addr_i;
    assign bus.jump_addr_o  = (state == WAKE) ? resume_pc
                                              : bus.jump_addr_i;

`ifdef GS_IF_CTRL_PERF_EN
    gs_sat_counter #(.WIDTH(32)) u_redir_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc_i (issue),
        .cnt_o (bus.redirect_cnt_o)
    );

    gs_sat_counter #(.WIDTH(32)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc_i (stall),
        .cnt_o (bus.stall_cnt_o)
    );
`else
    logic unused_perf;
    assign unused_perf        = issue ^ stall;
    assign bus.redirect_cnt_o = '0;
    assign bus.stall_cnt_o    = '0;
`endif

endmodule

// File: doc/gs_if_ctrl.md
# gs_if_ctrl

Fetch sequencer for the GoldenSnitch IF stage. It drives the stage's PC-select, branch/jump target, halt and flush inputs, covering:
- the post-reset boot sequence;
- branch and jump redirects from ID/EX;
- stall merging from hazard, memory and back-pressure sources;
- core sleep/wake with resume-PC save.

It sits beside the IF stage in the core top and is the only driver of the IF control inputs.

## Interface
- BOOT_DELAY, 2: cycles held in reset-wait before boot fetch (≥1)
- ADDR_SIZE, 32: address width
- clk  in  1  core clock
- rst  in  1  asynchronous active-low reset
- fetch_en_i  in  1  core enable; low requests sleep
- br_taken_i  in  1  EX resolved taken branch
- br_addr_i  in  ADDR_SIZE  branch target
- jump_i  in  1  ID decoded jump
- jump_addr_i  in  ADDR_SIZE  jump target
- pc_i  in  ADDR_SIZE  current IF PC (pc_out of IF stage)
- ld_use_i  in  1  load-use hazard stall
- id_ready_i  in  1  ID can accept
- mem_busy_i  in  1  instruction memory not ready
- pc_mux_sel_o  out  4  PC source to IF
- br_addr_o  out  ADDR_SIZE  branch target to IF
- jump_addr_o  out  ADDR_SIZE  jump target to IF
- halt_if_o  out  1  freeze IF
- flush_if_o  out  1  clear IF registers
- flush_id_o  out  1  squash IF/ID instruction
- boot_done_o  out  1  registered; high from first RUN cycle until reset
- redirect_cnt_o  out  32  taken redirects (perf)
- stall_cnt_o  out  32  halted RUN cycles (perf)

## Operation
- PC_* encodings (gs_pkg): PC_BOOT=4'd0, PC_NORMAL=4'd1, PC_BRNACH=4'd2, PC_JUMP=4'd3.
- Outputs are combinational from state and inputs, except boot_done_o and the counters.
- FSM states: RST_WAIT, BOOT, RUN, PEND, SLEEP, WAKE.
- **RST_WAIT**
  - Outputs: pc_mux=PC_NORMAL, halt=1.
  - 3-bit counter increments to BOOT_DELAY-1 and then saturates.
  - Goes to BOOT when saturated and fetch_en_i=1.
- **BOOT**
  - Outputs: pc_mux=PC_BOOT, halt=0 for one cycle, then RUN.
  - Redirect inputs are ignored.
- **RUN**
  - Redirect priority: br_taken_i over jump_i. On a simultaneous branch and jump, the jump is dropped.
  - Redirect with mem_busy_i=0: pc_mux=PC_BRNACH or PC_JUMP, halt=0 (overrides ld_use/id_ready), flush_id=1. Stay in RUN.
  - Redirect with mem_busy_i=1: latch target into pend_addr, halt=1, flush_id=1, go to PEND.
  - fetch_en_i=0 with no redirect: resume_pc<=pc_i, flush_if=1, halt=1, go to SLEEP.
  - fetch_en_i=0 with a redirect: resume_pc<=redirect target, flush_if=1, halt=1, go to SLEEP. The redirect is not issued to IF.
  - Otherwise: pc_mux=PC_NORMAL, halt=ld_use_i|~id_ready_i|mem_busy_i.
- **PEND**
  - Outputs: halt=1, flush_id=1. Redirect inputs are ignored because the pipeline is already squashed.
  - When mem_busy_i=0: pc_mux=PC_BRNACH, br_addr_o=pend_addr, halt=0, go to RUN.
  - fetch_en_i=0: resume_pc<=pend_addr, go to SLEEP.
- **SLEEP**
  - Outputs: halt=1, pc_mux=PC_NORMAL.
  - A late br_taken_i or jump_i overwrites resume_pc (branch priority).
  - fetch_en_i=1 goes to WAKE.
- **WAKE**
  - pc_mux=PC_JUMP, jump_addr_o=resume_pc.
  - halt=mem_busy_i; go to RUN when mem_busy_i=0.
- Address output muxing:
  - br_addr_o = pend_addr in PEND, else br_addr_i.
  - jump_addr_o = resume_pc in WAKE, else jump_addr_i.

## Timing
- All outputs at reset: pc_mux=PC_NORMAL, halt=1, flush_if=0, flush_id=0, boot_done=0, counters 0.
- State registers at reset: state=RST_WAIT, counter=0, pend_addr=0, resume_pc=0.
- First PC_BOOT cycle is cycle BOOT_DELAY after reset deassertion, given fetch_en_i=1.
- Redirect latency is zero: the target appears on pc_mux/addr in the same cycle as br_taken_i/jump_i.
- flush_id_o is high in the redirect cycle and in every PEND cycle.
- flush_if_o is a single-cycle pulse on RUN→SLEEP and on PEND→SLEEP.
- Reset mid-operation returns to RST_WAIT and clears pend_addr/resume_pc; no redirect survives reset.

## Configuration
- GS_IF_CTRL_PERF_EN defined:
  - redirect_cnt_o increments on each redirect issued to IF (RUN redirect, PEND release).
  - stall_cnt_o increments on each RUN cycle with halt_if_o=1.
  - Both saturate at 32'hFFFF_FFFF.
- GS_IF_CTRL_PERF_EN undefined: both outputs are tied to 0, no counter flops; ports are unchanged.

## Structure
- gs_pkg holds the PC_* localparams and the if_ctrl_state_e enum (3-bit).
- One sub-module, gs_sat_counter (parameter WIDTH, inputs clk/rst/inc_i, output cnt_o), is instantiated twice under GS_IF_CTRL_PERF_EN.

## Test plan
- Reset release with BOOT_DELAY=2, fetch_en=1 → PC_BOOT on cycle 2, RUN and boot_done=1 on cycle 3.
- RUN, br_taken=1, br_addr=0x100, jump=1, jump_addr=0x200 same cycle → pc_mux=PC_BRNACH, br_addr_o=0x100, flush_id=1, halt=0.
- RUN, jump_addr=0x40 with mem_busy=1 for 3 cycles → PEND with halt=1 for 3 cycles, then PC_BRNACH with br_addr_o=0x40 in cycle 4.
- RUN, pc_i=0x80, fetch_en→0 → flush_if pulse, SLEEP; fetch_en→1 → WAKE with PC_JUMP, jump_addr_o=0x80.
- SLEEP with br_taken, br_addr=0x300, then wake → jump_addr_o=0x300.
- PERF_EN: 5 cycles ld_use=1 in RUN → stall_cnt_o=5; without the macro → stall_cnt_o stays 0.
